pipe_upsize: RTL and testbench
==============================

# pipe_upsize

Valid/stall width upsizer that sits directly downstream of a 32-bit pipe stage and packs consecutive 32-bit words into one wide beat for the wider datapath that follows. It accepts words on a valid/stall input, accumulates RATIO words (or fewer when a packet ends early), and presents each completed beat from a registered output with a lane mask and last flag. The input side follows the same valid/stall handshake as the pipe stages, so it chains directly onto any of them.

## Interface
- IN_W, 32, width of one input word
- RATIO, 4, input words per output beat; power of two, 2..16
- clk  input  1  clock
- arst_n  input  1  reset; asynchronous, active-low
- i_valid  input  1  input word present
- i_data  input  IN_W  input word
- i_last  input  1  word is final word of its packet
- i_stall  output  1  upstream must hold i_valid/i_data/i_last
- o_valid  output  1  output beat present
- o_data  output  IN_W*RATIO  packed beat; word k in bits [k*IN_W +: IN_W]
- o_mask  output  RATIO  bit k set = lane k holds a valid word
- o_last  output  1  beat ends a packet
- o_stall  input  1  downstream not accepting

## Operation
- Input transfer: i_valid & !i_stall. Output transfer: o_valid & !o_stall.
- i_stall = o_valid & o_stall (combinational, same rule as a valid/data pipe stage).
- State: lane counter cnt (clog2(RATIO) bits), accumulator acc (IN_W*RATIO), output registers o_valid/o_data/o_mask/o_last.
- On input transfer with cnt < RATIO-1 and !i_last: acc lane cnt <= i_data; cnt <= cnt+1.
- On input transfer with cnt == RATIO-1 or i_last (completion):
  - o_data <= acc with lane cnt replaced by i_data, lanes above cnt forced to zero.
  - o_mask <= bits 0..cnt set, others clear.
  - o_last <= i_last.
  - o_valid <= 1; cnt <= 0; acc <= 0.
- Output transfer without completion in same cycle: o_valid <= 0; o_data/o_mask/o_last hold their last values.
- Output transfer and completion in same cycle: new beat loads, o_valid stays 1 (no bubble).
- While o_valid & o_stall: o_data/o_mask/o_last/o_valid frozen; no input accepted; cnt and acc frozen.
- Non-completing words are accepted while o_valid & !o_stall. The output register is not touched by them.
- i_last with cnt == RATIO-1 gives a full mask and o_last=1.
- A packet of exactly k*RATIO words gives k beats, all with full masks. Only the last beat has o_last=1.
- No flush without i_last: a partial beat stays in acc indefinitely.

## Timing
- Reset (arst_n low, async): o_valid=0, o_data=0, o_mask=0, o_last=0, cnt=0, acc=0; hence i_stall=0.
- Reset mid-packet discards acc contents and any held output beat. The first word after reset goes to lane 0.
- Latency: completing word accepted in cycle N gives o_valid=1 in cycle N+1.
- Throughput: one input word per cycle sustained while o_stall=0. One beat per RATIO cycles, or per packet end if sooner.
- o_stall reaches i_stall combinationally in the same cycle, gated by o_valid. Otherwise there is no combinational path from inputs to outputs.
- Upstream must keep i_valid/i_data/i_last stable while i_stall=1. The behaviour if they change is undefined.

## Test plan
- RATIO=4, words 0x11,0x22,0x33,0x44 (last on 0x44), o_stall=0 -> one cycle after 0x44: o_data=0x00000044_00000033_00000022_00000011, o_mask=4'b1111, o_last=1, o_valid for exactly 1 cycle.
- Packet 0xA0,0xA1 with i_last on 0xA1 -> o_data upper 64 bits zero, lower =0x000000A1_000000A0, o_mask=4'b0011, o_last=1. Single-word packet 0xB0 -> o_mask=4'b0001.
- 8 back-to-back words 1..8, last on 8, o_stall=0 -> i_stall never asserts. Beat 1 is words 1..4 with o_last=0. Beat 2 is words 5..8 with o_last=1. o_valid is 1 in both consecutive completion cycles with no bubble.
- First beat complete, o_stall=1 for 5 cycles while input keeps offering word 5 -> i_stall=1 for those cycles, and o_data/o_mask/o_last are stable. On o_stall=0, word 5 is accepted into lane 0 that same cycle and is never lost or duplicated.
- 2 words accepted, then arst_n pulsed low mid-cycle -> o_valid, o_mask and cnt go to 0 immediately. The next packet 0xC0..0xC3 yields o_data lane 0 = 0xC0, with no stale data in any lane.
- Random i_valid/o_stall over 10k words, scoreboard on packet boundaries -> every word appears exactly once, in order. Masks are contiguous from bit 0, o_last aligns with i_last, and i_stall is never 1 while o_valid=0.

Source files
------------

// File: rtl/pipe_upsize.sv
// pipe_upsize: packs RATIO consecutive IN_W-bit words from a valid/stall pipe into one wide beat
// with a lane mask and packet-last flag; a packet end flushes a partial beat early.
module pipe_upsize #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_valid,
  input  logic [IN_W-1:0]       i_data,
  input  logic                  i_last,
  output logic                  i_stall,
  output logic                  o_valid,
  output logic [IN_W*RATIO-1:0] o_data,
  output logic [RATIO-1:0]      o_mask,
  output logic                  o_last,
  input  logic                  o_stall
);
  localparam int W  = IN_W * RATIO;
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] TOP = CW'(RATIO - 1);
  logic [CW-1:0]    cnt;
  logic [W-1:0]     acc;
  logic [W-1:0]     beat;
  logic [RATIO-1:0] mask;
  logic             in_xfer, out_xfer, done;
  assign i_stall  = o_valid & o_stall;
  assign in_xfer  = i_valid & ~i_stall;
  assign out_xfer = o_valid & ~o_stall;
  assign done     = in_xfer & (cnt == TOP | i_last);
  // Lanes at and above cnt in acc are always zero (cleared on every completion),
  // so OR-ing the new word into lane cnt also zero-fills the unused upper lanes.
  assign beat = acc | ({{(W-IN_W){1'b0}}, i_data} << (cnt * IN_W));
  assign mask = {RATIO{1'b1}} >> (RATIO - 1 - int'(cnt));
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      cnt     <= '0;
      acc     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_mask  <= '0;
      o_last  <= 1'b0;
    end else if (done) begin
      o_valid <= 1'b1;
      o_data  <= beat;
      o_mask  <= mask;
      o_last  <= i_last;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      if (out_xfer) o_valid <= 1'b0;
      if (in_xfer) begin
        acc[cnt*IN_W +: IN_W] <= i_data;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_pipe_upsize.sv
// tb_pipe_upsize: directed steps plus a random run, checked against a bench-side packing scoreboard.
module tb_pipe_upsize;
  localparam int IN_W  = 32;
  localparam int RATIO = 4;
  localparam int W     = IN_W * RATIO;
  typedef struct {
    logic [W-1:0]     d;
    logic [RATIO-1:0] m;
    logic             l;
  } beat_t;
  logic clk = 1'b0, arst_n = 1'b0;
  logic i_valid = 1'b0, i_last = 1'b0, i_stall, o_valid, o_last, o_stall = 1'b0;
  logic [IN_W-1:0]  i_data = '0;
  logic [W-1:0]     o_data, hold_d;
  logic [RATIO-1:0] o_mask, hold_m;
  logic             hold_l;
  logic             took, rnd = 1'b0;
  int checks = 0, failures = 0;
  beat_t exp_q[$];
  logic [IN_W-1:0] cur[$];

  pipe_upsize #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk(clk), .arst_n(arst_n), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .i_stall(i_stall), .o_valid(o_valid), .o_data(o_data), .o_mask(o_mask),
    .o_last(o_last), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample just after the falling edge, score the handshakes that the next rising edge performs.
  task automatic tick();
    beat_t b, e;
    if (rnd) o_stall = ($urandom_range(0, 3) == 0);
    #1;
    chk("i_stall_rule", i_stall, o_valid & o_stall);
    took = i_valid & ~i_stall;
    if (o_valid && !o_stall) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=%h expected=none", o_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", o_data, e.d);
        chk("beat_mask", o_mask, e.m);
        chk("beat_last", o_last, e.l);
      end
    end
    if (took) begin
      cur.push_back(i_data);
      if (cur.size() == RATIO || i_last) begin
        b.d = '0;
        foreach (cur[k]) b.d[k*IN_W +: IN_W] = cur[k];
        b.m = RATIO'((1 << cur.size()) - 1);
        b.l = i_last;
        exp_q.push_back(b);
        cur.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    do begin
      tick();
      n++;
    end while (!took && n < 200);
    if (!took) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    o_stall = 1'b0;
    rnd     = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_mask", o_mask, '0);
    chk("rst_o_last", o_last, 1'b0);
    o_stall = 1'b1;
    #1 chk("rst_i_stall", i_stall, 1'b0);
    o_stall = 1'b0;
    arst_n = 1'b1;
    @(negedge clk);
    // full packet, single beat
    send(32'h11, 0); send(32'h22, 0); send(32'h33, 0); send(32'h44, 1);
    i_valid = 1'b0;
    chk("t1_valid", o_valid, 1'b1);
    chk("t1_data", o_data, 128'h00000044_00000033_00000022_00000011);
    chk("t1_mask", o_mask, 4'b1111);
    chk("t1_last", o_last, 1'b1);
    idle(1);
    chk("t1_one_cycle", o_valid, 1'b0);
    // short packets
    send(32'hA0, 0); send(32'hA1, 1);
    i_valid = 1'b0;
    chk("t2_data", o_data, 128'h000000A1_000000A0);
    chk("t2_mask", o_mask, 4'b0011);
    send(32'hB0, 1);
    i_valid = 1'b0;
    chk("t2_single_mask", o_mask, 4'b0001);
    chk("t2_single_last", o_last, 1'b1);
    idle(2);
    // back-to-back two beats, no bubble
    for (int i = 1; i <= 8; i++) begin
      send(IN_W'(i), i == 8);
      chk("t3_no_stall", i_stall, 1'b0);
      if (i == 4 || i == 8) chk("t3_valid", o_valid, 1'b1);
      if (i == 4) chk("t3_first_last", o_last, 1'b0);
    end
    idle(2);
    // downstream stall with word 5 waiting
    for (int i = 1; i <= 4; i++) send(IN_W'(32'h50 + i), 0);
    hold_d = o_data; hold_m = o_mask; hold_l = o_last;
    o_stall = 1'b1;
    i_valid = 1'b1; i_data = 32'h55; i_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_i_stall", i_stall, 1'b1);
      chk("t4_data_hold", o_data, hold_d);
      chk("t4_mask_hold", o_mask, hold_m);
      chk("t4_last_hold", o_last, hold_l);
    end
    o_stall = 1'b0;
    send(32'h55, 0);
    send(32'h56, 0); send(32'h57, 0); send(32'h58, 1);
    idle(2);
    drain();
    // async reset mid-packet
    send(32'hD0, 0); send(32'hD1, 0);
    i_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    chk("t5_rst_valid", o_valid, 1'b0);
    chk("t5_rst_mask", o_mask, '0);
    cur.delete();
    exp_q.delete();
    arst_n = 1'b1;
    @(negedge clk);
    send(32'hC0, 0); send(32'hC1, 0); send(32'hC2, 0); send(32'hC3, 1);
    i_valid = 1'b0;
    chk("t5_data", o_data, 128'h000000C3_000000C2_000000C1_000000C0);
    drain();
    // random traffic
    rnd = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send($urandom, $urandom_range(0, 6) == 0);
    end
    send(32'hFFFF_0000, 1);
    drain();
    chk("partial_empty", W'(cur.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
